// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and writeback arbiter parameters used by
// wb_arbiter and its 2-entry pending-write FIFO.
package wb_arbiter_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;

    localparam logic [RegAddrBus-1:0] NOPRegAddr  = 5'h0;
    localparam logic                  WriteEnable = 1'b1;
    localparam logic [RegBus-1:0]     ZeroWord    = 32'h0;

    localparam int         WbFifoDepth   = 2;
    localparam int         WbPtrBits     = $clog2(WbFifoDepth);
    localparam logic [2:0] WbStarveLimit = 3'd7;

    // Register 0 is hardwired, so a write to it never occupies the port.
    function automatic logic slot_busy(input logic we, input logic [RegAddrBus-1:0] addr);
        return we && (addr != NOPRegAddr);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order FIFO of pending multi-cycle writebacks, with per-entry
// valids, same-address invalidation and operand-address match outputs.
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [RegAddrBus-1:0] push_addr,
    input  logic [RegBus-1:0]     push_data,
    input  logic                  pop,
    input  logic                  inv_en,
    input  logic [RegAddrBus-1:0] inv_addr,
    input  logic [RegAddrBus-1:0] q_raddr1,
    input  logic [RegAddrBus-1:0] q_raddr2,
    output logic                  empty,
    output logic                  full,
    output logic [RegAddrBus-1:0] head_addr,
    output logic [RegBus-1:0]     head_data,
    output logic                  match1,
    output logic                  match2
);

    logic [RegAddrBus-1:0]  addr_q [WbFifoDepth];
    logic [RegBus-1:0]      data_q [WbFifoDepth];
    logic [WbFifoDepth-1:0] valid_q;
    logic [WbPtrBits-1:0]   rd_ptr;

    logic [WbFifoDepth-1:0] kept;
    logic [WbFifoDepth-1:0] push_mask;
    logic [WbPtrBits-1:0]   rd_next;
    logic [WbPtrBits-1:0]   wr_slot;

    // Survivors are kept compact behind rd_ptr: if the head dies but the
    // younger entry lives, the read pointer steps onto it.
    always_comb begin
        kept = valid_q;
        for (int i = 0; i < WbFifoDepth; i++) begin
            if (inv_en && valid_q[i] && (addr_q[i] == inv_addr)) begin
                kept[i] = 1'b0;
            end
        end
        if (pop) begin
            kept[rd_ptr] = 1'b0;
        end
        rd_next = rd_ptr;
        if (!kept[rd_ptr] && kept[~rd_ptr]) begin
            rd_next = ~rd_ptr;
        end
        wr_slot   = kept[rd_next] ? ~rd_next : rd_next;
        push_mask = '0;
        if (push) begin
            push_mask[wr_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            rd_ptr  <= '0;
        end else begin
            valid_q <= kept | push_mask;
            rd_ptr  <= rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_slot] <= push_addr;
            data_q[wr_slot] <= push_data;
        end
    end

    always_comb begin
        empty     = ~|valid_q;
        full      = &valid_q;
        head_addr = addr_q[rd_ptr];
        head_data = data_q[rd_ptr];
        match1    = 1'b0;
        match2    = 1'b0;
        for (int i = 0; i < WbFifoDepth; i++) begin
            if (valid_q[i] && (addr_q[i] == q_raddr1)) match1 = 1'b1;
            if (valid_q[i] && (addr_q[i] == q_raddr2)) match2 = 1'b1;
        end
        match1 = match1 && (q_raddr1 != NOPRegAddr);
        match2 = match2 && (q_raddr2 != NOPRegAddr);
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, multi-cycle
// results queue in a 2-entry FIFO and raise stall_req if starved too long.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [RegAddrBus-1:0] wb_waddr,
    input  logic [RegBus-1:0]     wb_wdata,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic [RegAddrBus-1:0] div_waddr,
    input  logic [RegBus-1:0]     div_wdata,
    output logic                  reg_we,
    output logic [RegAddrBus-1:0] reg_waddr,
    output logic [RegBus-1:0]     reg_wdata,
    input  logic [RegAddrBus-1:0] q_raddr1,
    input  logic [RegAddrBus-1:0] q_raddr2,
    output logic                  q_pend1,
    output logic                  q_pend2,
    output logic                  stall_req
);

    logic                  busy;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [RegAddrBus-1:0] head_addr;
    logic [RegBus-1:0]     head_data;
    logic [2:0]            starve_cnt;
    logic [2:0]            starve_next;

    // Writes to register 0 complete the handshake but are never queued.
    always_comb begin
        busy      = slot_busy(wb_we, wb_waddr);
        div_ready = !rst && !full;
        push      = div_valid && div_ready && (div_waddr != NOPRegAddr);
        pop       = !busy && !empty;
    end

    wb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (div_waddr),
        .push_data (div_wdata),
        .pop       (pop),
        .inv_en    (busy),
        .inv_addr  (wb_waddr),
        .q_raddr1  (q_raddr1),
        .q_raddr2  (q_raddr2),
        .empty     (empty),
        .full      (full),
        .head_addr (head_addr),
        .head_data (head_data),
        .match1    (q_pend1),
        .match2    (q_pend2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_we    <= 1'b0;
            reg_waddr <= NOPRegAddr;
            reg_wdata <= ZeroWord;
        end else if (busy) begin
            reg_we    <= WriteEnable;
            reg_waddr <= wb_waddr;
            reg_wdata <= wb_wdata;
        end else if (pop) begin
            reg_we    <= WriteEnable;
            reg_waddr <= head_addr;
            reg_wdata <= head_data;
        end else begin
            reg_we    <= 1'b0;
        end
    end

    // Counter saturates at the limit; stall_req stays up until the FIFO is served.
    always_comb begin
        starve_next = starve_cnt;
        if (pop || empty) begin
            starve_next = '0;
        end else if (starve_cnt != WbStarveLimit) begin
            starve_next = starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            if (pop || empty) begin
                stall_req <= 1'b0;
            end else if (starve_next == WbStarveLimit) begin
                stall_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected register-file writes are queued
// as stimulus is driven and matched against every reg_we pulse.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [4:0]  q_raddr1;
    logic [4:0]  q_raddr2;
    logic        q_pend1;
    logic        q_pend2;
    logic        stall_req;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   compared;
    int   mismatched;
    bit   mon_en;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_waddr (div_waddr),
        .div_wdata (div_wdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .q_raddr1  (q_raddr1),
        .q_raddr2  (q_raddr2),
        .q_pend1   (q_pend1),
        .q_pend2   (q_pend2),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write-port pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en && reg_we === 1'b1) begin
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL sb_unexpected: got write addr=%0d data=%h, required no write",
                         reg_waddr, reg_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                if ({reg_waddr, reg_wdata} !== {mon_e.addr, mon_e.data}) begin
                    mismatched++;
                    $display("[TB] FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             reg_waddr, reg_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we     = 1'b0;
        wb_waddr  = 5'd0;
        wb_wdata  = 32'h0;
        div_valid = 1'b0;
        div_waddr = 5'd0;
        div_wdata = 32'h0;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        sb_q.push_back('{addr: a, data: d});
    endtask

    task automatic drive_div(input logic [4:0] a, input logic [31:0] d);
        div_valid = 1'b1;
        div_waddr = a;
        div_wdata = d;
    endtask

    task automatic test_sb_drained(input string name);
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s_drained: got %0d writes outstanding, required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        div_valid = 1'b1;
        div_waddr = 5'd5;
        q_raddr1  = 5'd5;
        q_raddr2  = 5'd0;
        repeat (2) step();
        compared += 5;
        if ({reg_we, reg_waddr, reg_wdata} !== 38'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_reg: got we=%b addr=%0d data=%h, required all 0", reg_we, reg_waddr, reg_wdata);
        end
        if (stall_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_stall: got %b, required 0", stall_req);
        end
        if (div_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: got %b, required 0", div_ready);
        end
        if (q_pend1 !== 1'b0 || q_pend2 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_pend: got %b%b, required 00", q_pend1, q_pend2);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_ready: got %b, required 1", div_ready);
        end
        mon_en = 1'b1;
        step();
        compared++;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_we: got %b, required 0", reg_we);
        end
    endtask

    task automatic test_wb_write();
        drive_wb(5'd5, 32'h1234);
        step();
        compared++;
        if (reg_we !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wb_latency: got reg_we=%b, required 1", reg_we);
        end
        idle_inputs();
        step();
        compared++;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wb_single: got reg_we=%b, required 0", reg_we);
        end
        wb_we    = 1'b1;
        wb_waddr = 5'd0;
        wb_wdata = 32'hFFFF;
        step();
        compared++;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wb_addr0: got reg_we=%b, required 0", reg_we);
        end
        for (int i = 1; i <= 3; i++) begin
            drive_wb(5'(i + 16), $urandom);
            step();
        end
        idle_inputs();
        step();
        test_sb_drained("wb_write");
    endtask

    task automatic test_div_latency();
        q_raddr1 = 5'd7;
        q_raddr2 = 5'd8;
        drive_div(5'd7, 32'hAA);
        #1;
        compared++;
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL div_ready_empty: got %b, required 1", div_ready);
        end
        sb_q.push_back('{addr: 5'd7, data: 32'hAA});
        step();
        idle_inputs();
        #1;
        compared += 3;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL div_no_bypass: got reg_we=%b, required 0", reg_we);
        end
        if (q_pend1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL div_pend1: got %b, required 1", q_pend1);
        end
        if (q_pend2 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL div_pend2: got %b, required 0", q_pend2);
        end
        step();
        compared += 2;
        if (reg_we !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL div_latency: got reg_we=%b, required 1", reg_we);
        end
        if (q_pend1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL div_pend_cleared: got %b, required 0", q_pend1);
        end
        step();
        test_sb_drained("div_latency");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            drive_div(5'(10 + i), d);
            sb_q.push_back('{addr: 5'(10 + i), data: d});
            #1;
            compared++;
            if (div_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_ready%0d: got %b, required 1", i, div_ready);
            end
            step();
        end
        idle_inputs();
        repeat (3) step();
        test_sb_drained("back_to_back");
    endtask

    task automatic test_stall();
        exp_t held[$];
        drive_wb(5'd20, $urandom);
        drive_div(5'd3, 32'h33);
        held.push_back('{addr: 5'd3, data: 32'h33});
        step();
        drive_wb(5'd21, $urandom);
        drive_div(5'd4, 32'h44);
        held.push_back('{addr: 5'd4, data: 32'h44});
        step();
        div_valid = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            drive_wb(5'(20 + k), $urandom);
            #1;
            if (k == 2) begin
                compared++;
                if (div_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL full_ready: got %b, required 0", div_ready);
                end
            end
            step();
            compared++;
            if (stall_req !== (k >= 7)) begin
                mismatched++;
                $display("[TB] FAIL stall_after_%0d: got %b, required %b", k, stall_req, k >= 7);
            end
        end
        idle_inputs();
        sb_q.push_back(held.pop_front());
        step();
        compared += 2;
        if (stall_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_clear: got %b, required 0", stall_req);
        end
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drain_ready: got %b, required 1", div_ready);
        end
        sb_q.push_back(held.pop_front());
        repeat (2) step();
        test_sb_drained("stall");
    endtask

    task automatic test_waw();
        q_raddr1 = 5'd9;
        drive_div(5'd9, 32'h99);
        step();
        idle_inputs();
        drive_wb(5'd9, 32'h999);
        #1;
        compared++;
        if (q_pend1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL waw_pend_before: got %b, required 1", q_pend1);
        end
        step();
        idle_inputs();
        #1;
        compared++;
        if (q_pend1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL waw_pend_after: got %b, required 0", q_pend1);
        end
        step();
        compared++;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL waw_dropped: got reg_we=%b, required 0", reg_we);
        end
        drive_wb(5'd9, 32'h1111);
        drive_div(5'd9, 32'h77);
        sb_q.push_back('{addr: 5'd9, data: 32'h77});
        step();
        idle_inputs();
        #1;
        compared++;
        if (q_pend1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL waw_younger_kept: got %b, required 1", q_pend1);
        end
        repeat (3) step();
        test_sb_drained("waw");
    endtask

    task automatic test_zero_addr();
        q_raddr1 = 5'd0;
        drive_wb(5'd1, $urandom);
        drive_div(5'd0, 32'hDEAD);
        #1;
        compared++;
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_ready0: got %b, required 1", div_ready);
        end
        step();
        drive_wb(5'd2, $urandom);
        step();
        idle_inputs();
        #1;
        compared++;
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_not_stored: got div_ready=%b, required 1", div_ready);
        end
        step();
        compared++;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_no_write: got reg_we=%b, required 0", reg_we);
        end
        step();
        test_sb_drained("zero_addr");
    endtask

    task automatic test_reset_mid_drain();
        q_raddr1 = 5'd12;
        drive_wb(5'd21, $urandom);
        drive_div(5'd11, 32'hB1);
        step();
        drive_wb(5'd22, $urandom);
        drive_div(5'd12, 32'hB2);
        step();
        idle_inputs();
        sb_q.push_back('{addr: 5'd11, data: 32'hB1});
        step();
        compared++;
        if (q_pend1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drain_pend: got %b, required 1", q_pend1);
        end
        #2;
        rst = 1'b1;
        #1;
        compared += 3;
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_we: got %b, required 0", reg_we);
        end
        if (div_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_ready: got %b, required 0", div_ready);
        end
        if (q_pend1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_pend: got %b, required 0", q_pend1);
        end
        step();
        rst = 1'b0;
        step();
        compared += 3;
        if (div_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL post_reset_ready: got %b, required 1", div_ready);
        end
        if (q_pend1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_empty: got q_pend1=%b, required 0", q_pend1);
        end
        if (reg_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_we: got %b, required 0", reg_we);
        end
        repeat (2) step();
        test_sb_drained("reset_mid_drain");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        test_reset();
        test_wb_write();
        test_div_latency();
        test_back_to_back();
        test_stall();
        test_waw();
        test_zero_addr();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
